wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the 8-bit pipeline. It consumes the outputs of the EX/WB pipeline register, selects the write-back value (ALU result or immediate), and commits it to an 8-entry × 8-bit register file. It serves two combinational read ports to decode with same-cycle write bypass, and keeps a saturating retired-instruction counter and a last-write debug record.

## Interface

Parameters:
- DATA_W, 8, register and data width
- NREGS, 8, number of registers
- ADDR_W, 3, register address width; NREGS == 2**ADDR_W
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- WB_regwrite  in  1  commit enable for this cycle's write-back
- WB_ImmLoad  in  1  1: write WB_ImmData; 0: write WB_ALUres
- WB_ALUres  in  DATA_W  ALU result from EX/WB
- WB_ImmData  in  DATA_W  immediate data from EX/WB
- WB_writereg  in  ADDR_W  destination register index
- WB_instr  in  8  instruction in WB; 8'h00 is the bubble/NOP encoding
- ID_readreg1  in  ADDR_W  read port 1 index
- ID_readreg2  in  ADDR_W  read port 2 index
- ID_readdata1  out  DATA_W  read port 1 data, combinational
- ID_readdata2  out  DATA_W  read port 2 data, combinational
- WB_writedata  out  DATA_W  selected write-back value, combinational
- retire_count  out  CNT_W  registered count of retired non-bubble instructions
- last_wb_reg  out  ADDR_W  registered index of the most recent committed write
- last_wb_data  out  DATA_W  registered data of the most recent committed write

## Operation

- Write-back select: WB_writedata = WB_ImmLoad ? WB_ImmData : WB_ALUres. This is independent of WB_regwrite.
- Commit: on a rising edge with rst high and WB_regwrite = 1, regs[WB_writereg] <= WB_writedata, last_wb_reg <= WB_writereg, and last_wb_data <= WB_writedata. All NREGS registers are writable; there is no hardwired zero register.
- Read with bypass, per port n: if rst is high, WB_regwrite = 1, and WB_writereg == ID_readregn, then ID_readdatan = WB_writedata. Otherwise ID_readdatan = regs[ID_readregn].
- Both ports can read the same index. Both ports can hit the bypass in the same cycle.
- Retire counter: increments by 1 on each rising edge with rst high and WB_instr != 8'h00. It saturates at all-ones and does not wrap. WB_regwrite does not affect it, so stores and branches still retire.
- Reset (rst low): asynchronously clears all registers, retire_count, last_wb_reg and last_wb_data to 0. While rst is low, writes are suppressed, bypass is disabled, and both read ports return 0.

## Timing

- Write latency: a committed value is visible through the array on the cycle after the edge. It is visible through the bypass in the same cycle that WB presents it.
- Read ports and WB_writedata are purely combinational. There is no clock-to-read latency.
- retire_count, last_wb_reg and last_wb_data update on the commit edge and are valid the following cycle.
- Reset values: ID_readdata1 = ID_readdata2 = 0, retire_count = 0, last_wb_reg = 0, last_wb_data = 0. WB_writedata follows its inputs even during reset.
- Reset mid-operation: asserting rst clears state immediately without waiting for a clock edge. An edge while rst is low commits nothing. The first edge after rst rises commits normally.
- Back-to-back writes to the same register: the later write wins. Bypass always reflects the current WB inputs.
- Saturation: at retire_count = 2**CNT_W−1, further retiring edges leave the value unchanged.

## Test plan

- Reset then read: pulse rst low between edges, then read all 8 indices. Require 8'h00 on both ports, retire_count = 0, last_wb_reg = 0 and last_wb_data = 0 immediately after rst falls, with no edge needed.
- Commit and select:
  - Write R3 with ALUres = 8'hA5, ImmLoad = 0. Next cycle ID_readdata1 (readreg1 = 3) = 8'hA5.
  - Write R3 with ImmLoad = 1, ImmData = 8'h3C, ALUres = 8'hFF. Next cycle the read returns 8'h3C and last_wb_data = 8'h3C.
- Bypass: R5 holds 8'h11. Present regwrite = 1, writereg = 5, ALUres = 8'h77 with both readregs = 5. Both ports read 8'h77 in the same cycle. With regwrite = 0 and the same inputs, both read 8'h11.
- Suppressed write: regwrite = 0, writereg = 2, ALUres = 8'h99. R2 is unchanged, and last_wb_reg and last_wb_data are unchanged.
- Retire counter: feed 6 cycles of WB_instr = 8'h12, 8'h00, 8'h34, 8'h00, 8'h56, 8'h78, so retire_count = 4. In a CNT_W = 4 build, 20 non-bubble cycles leave retire_count at 4'hF.
- Reset mid-write: assert rst low between edges while regwrite = 1, writereg = 1, ALUres = 8'hEE. R1 reads 0 after rst rises, and retire_count = 0.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile
// Write-back stage and architectural register file for the 8-bit pipeline.
// Selects the write-back value, commits it to an NREGS x DATA_W array, and
// serves two combinational read ports with same-cycle write bypass. It also
// keeps a saturating retired-instruction counter and a last-write record.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous active-low reset
//   WB_regwrite   commit enable for this cycle's write-back
//   WB_ImmLoad    1: write WB_ImmData, 0: write WB_ALUres
//   WB_ALUres     ALU result from EX/WB
//   WB_ImmData    immediate data from EX/WB
//   WB_writereg   destination register index
//   WB_instr      instruction in WB (8'h00 = bubble)
//   ID_readreg1/2 read port indices
//   ID_readdata1/2 read port data (combinational, bypassed)
//   WB_writedata  selected write-back value (combinational)
//   retire_count  saturating count of retired non-bubble instructions
//   last_wb_reg   index of the most recent committed write
//   last_wb_data  data of the most recent committed write
module wb_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_regwrite,
  input  logic              WB_ImmLoad,
  input  logic [DATA_W-1:0] WB_ALUres,
  input  logic [DATA_W-1:0] WB_ImmData,
  input  logic [ADDR_W-1:0] WB_writereg,
  input  logic [7:0]        WB_instr,
  input  logic [ADDR_W-1:0] ID_readreg1,
  input  logic [ADDR_W-1:0] ID_readreg2,
  output logic [DATA_W-1:0] ID_readdata1,
  output logic [DATA_W-1:0] ID_readdata2,
  output logic [DATA_W-1:0] WB_writedata,
  output logic [CNT_W-1:0]  retire_count,
  output logic [ADDR_W-1:0] last_wb_reg,
  output logic [DATA_W-1:0] last_wb_data
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_active;

  assign WB_writedata = WB_ImmLoad ? WB_ImmData : WB_ALUres;

  // A write is only live while out of reset; this gates both the array
  // commit (implicitly, via the async clear) and the bypass path.
  assign wr_active = rst & WB_regwrite;

  always_comb begin
    ID_readdata1 = '0;
    ID_readdata2 = '0;
    if (rst) begin
      if (wr_active && (WB_writereg == ID_readreg1))
        ID_readdata1 = WB_writedata;
      else
        ID_readdata1 = regs[ID_readreg1];

      if (wr_active && (WB_writereg == ID_readreg2))
        ID_readdata2 = WB_writedata;
      else
        ID_readdata2 = regs[ID_readreg2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      last_wb_reg  <= '0;
      last_wb_data <= '0;
    end else if (WB_regwrite) begin
      regs[WB_writereg] <= WB_writedata;
      last_wb_reg       <= WB_writereg;
      last_wb_data      <= WB_writedata;
    end
  end

  // Retirement is independent of regwrite so stores and branches count.
  // The counter holds at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      retire_count <= '0;
    else if ((WB_instr != 8'h00) && (retire_count != {CNT_W{1'b1}}))
      retire_count <= retire_count + 1'b1;
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic       clk;
  logic       rst;
  logic       WB_regwrite;
  logic       WB_ImmLoad;
  logic [7:0] WB_ALUres;
  logic [7:0] WB_ImmData;
  logic [2:0] WB_writereg;
  logic [7:0] WB_instr;
  logic [2:0] ID_readreg1;
  logic [2:0] ID_readreg2;

  logic [7:0]  rd1, rd2, wdata;
  logic [15:0] rcount;
  logic [2:0]  lreg;
  logic [7:0]  ldata;

  logic [7:0] rd1_s, rd2_s, wdata_s;
  logic [3:0] rcount_s;
  logic [2:0] lreg_s;
  logic [7:0] ldata_s;

  int total = 0;
  int bad = 0;

  // Reference model
  logic [7:0] m_regs [8];
  int         m_cnt;
  int         m_cnt4;
  logic [2:0] m_lreg;
  logic [7:0] m_ldata;

  wb_regfile u_dut (
    .clk(clk), .rst(rst),
    .WB_regwrite(WB_regwrite), .WB_ImmLoad(WB_ImmLoad),
    .WB_ALUres(WB_ALUres), .WB_ImmData(WB_ImmData),
    .WB_writereg(WB_writereg), .WB_instr(WB_instr),
    .ID_readreg1(ID_readreg1), .ID_readreg2(ID_readreg2),
    .ID_readdata1(rd1), .ID_readdata2(rd2),
    .WB_writedata(wdata), .retire_count(rcount),
    .last_wb_reg(lreg), .last_wb_data(ldata)
  );

  wb_regfile #(.CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst),
    .WB_regwrite(WB_regwrite), .WB_ImmLoad(WB_ImmLoad),
    .WB_ALUres(WB_ALUres), .WB_ImmData(WB_ImmData),
    .WB_writereg(WB_writereg), .WB_instr(WB_instr),
    .ID_readreg1(ID_readreg1), .ID_readreg2(ID_readreg2),
    .ID_readdata1(rd1_s), .ID_readdata2(rd2_s),
    .WB_writedata(wdata_s), .retire_count(rcount_s),
    .last_wb_reg(lreg_s), .last_wb_data(ldata_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_wdata();
    return WB_ImmLoad ? WB_ImmData : WB_ALUres;
  endfunction

  function automatic logic [7:0] exp_read(input logic [2:0] idx);
    if (!rst) return 8'h00;
    if (WB_regwrite && WB_writereg == idx) return exp_wdata();
    return m_regs[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_cnt = 0;
    m_cnt4 = 0;
    m_lreg = 3'd0;
    m_ldata = 8'h00;
  endtask

  // One rising edge; the model takes the inputs present at that edge.
  task automatic apply_edge();
    @(posedge clk);
    if (rst) begin
      if (WB_regwrite) begin
        m_regs[WB_writereg] = exp_wdata();
        m_lreg = WB_writereg;
        m_ldata = exp_wdata();
      end
      if (WB_instr != 8'h00) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      end
    end
    #1;
  endtask

  task automatic write_reg(input logic [2:0] r, input logic [7:0] v);
    WB_regwrite = 1'b1; WB_ImmLoad = 1'b0; WB_ALUres = v; WB_writereg = r;
    apply_edge();
    WB_regwrite = 1'b0;
  endtask

  task automatic test_reset();
    WB_instr = 8'h21;
    write_reg(3'd4, 8'hC3);
    write_reg(3'd7, 8'h5E);
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    total++;
    if (rcount !== 16'd0) begin bad++; $display("FAIL reset_count got=%h exp=0000", rcount); end
    total++;
    if (lreg !== 3'd0 || ldata !== 8'h00) begin
      bad++; $display("FAIL reset_last got=%0d/%h exp=0/00", lreg, ldata);
    end
    for (int i = 0; i < 8; i++) begin
      ID_readreg1 = 3'(i);
      ID_readreg2 = 3'(7 - i);
      #1;
      total++;
      if (rd1 !== 8'h00 || rd2 !== 8'h00) begin
        bad++; $display("FAIL reset_read idx=%0d got=%h/%h exp=00/00", i, rd1, rd2);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    WB_instr = 8'h00;
  endtask

  task automatic test_commit_select();
    write_reg(3'd3, 8'hA5);
    ID_readreg1 = 3'd3;
    #1;
    total++;
    if (rd1 !== 8'hA5) begin bad++; $display("FAIL commit_alu got=%h exp=a5", rd1); end
    WB_regwrite = 1'b1; WB_ImmLoad = 1'b1; WB_ImmData = 8'h3C;
    WB_ALUres = 8'hFF; WB_writereg = 3'd3;
    #1;
    total++;
    if (wdata !== 8'h3C) begin bad++; $display("FAIL select_imm got=%h exp=3c", wdata); end
    apply_edge();
    WB_regwrite = 1'b0;
    #1;
    total++;
    if (rd1 !== 8'h3C) begin bad++; $display("FAIL commit_imm got=%h exp=3c", rd1); end
    total++;
    if (ldata !== 8'h3C || lreg !== 3'd3) begin
      bad++; $display("FAIL commit_last got=%0d/%h exp=3/3c", lreg, ldata);
    end
  endtask

  task automatic test_bypass();
    write_reg(3'd5, 8'h11);
    WB_regwrite = 1'b1; WB_ImmLoad = 1'b0; WB_writereg = 3'd5; WB_ALUres = 8'h77;
    ID_readreg1 = 3'd5; ID_readreg2 = 3'd5;
    #1;
    total++;
    if (rd1 !== 8'h77 || rd2 !== 8'h77) begin
      bad++; $display("FAIL bypass_hit got=%h/%h exp=77/77", rd1, rd2);
    end
    WB_regwrite = 1'b0;
    #1;
    total++;
    if (rd1 !== 8'h11 || rd2 !== 8'h11) begin
      bad++; $display("FAIL bypass_off got=%h/%h exp=11/11", rd1, rd2);
    end
  endtask

  task automatic test_suppressed();
    write_reg(3'd2, 8'h42);
    write_reg(3'd6, 8'h5A);
    WB_regwrite = 1'b0; WB_ImmLoad = 1'b0; WB_writereg = 3'd2; WB_ALUres = 8'h99;
    apply_edge();
    ID_readreg1 = 3'd2;
    #1;
    total++;
    if (rd1 !== 8'h42) begin bad++; $display("FAIL suppress_reg got=%h exp=42", rd1); end
    total++;
    if (lreg !== 3'd6 || ldata !== 8'h5A) begin
      bad++; $display("FAIL suppress_last got=%0d/%h exp=6/5a", lreg, ldata);
    end
  endtask

  task automatic test_retire();
    logic [7:0] seq [6];
    seq[0] = 8'h12; seq[1] = 8'h00; seq[2] = 8'h34;
    seq[3] = 8'h00; seq[4] = 8'h56; seq[5] = 8'h78;
    rst = 1'b0;
    model_clear();
    #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      WB_instr = seq[i];
      apply_edge();
    end
    WB_instr = 8'h00;
    total++;
    if (rcount !== 16'd4) begin bad++; $display("FAIL retire_seq got=%0d exp=4", rcount); end
    for (int i = 0; i < 20; i++) begin
      WB_instr = 8'(1 + $urandom_range(0, 254));
      apply_edge();
    end
    WB_instr = 8'h00;
    total++;
    if (rcount_s !== 4'hF) begin bad++; $display("FAIL retire_sat got=%h exp=f", rcount_s); end
    total++;
    if (rcount !== 16'd24) begin bad++; $display("FAIL retire_wide got=%0d exp=24", rcount); end
    apply_edge();
    total++;
    if (rcount_s !== 4'hF) begin bad++; $display("FAIL retire_hold got=%h exp=f", rcount_s); end
  endtask

  task automatic test_reset_mid_write();
    WB_instr = 8'h44;
    WB_regwrite = 1'b1; WB_ImmLoad = 1'b0; WB_writereg = 3'd1; WB_ALUres = 8'hEE;
    #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #2;
    rst = 1'b1;
    WB_regwrite = 1'b0;
    WB_instr = 8'h00;
    ID_readreg1 = 3'd1;
    #1;
    total++;
    if (rd1 !== 8'h00) begin bad++; $display("FAIL mid_reset_r1 got=%h exp=00", rd1); end
    total++;
    if (rcount !== 16'd0 || rcount_s !== 4'd0) begin
      bad++; $display("FAIL mid_reset_count got=%0d/%0d exp=0/0", rcount, rcount_s);
    end
    WB_regwrite = 1'b1; WB_writereg = 3'd1; WB_ALUres = 8'hEE;
    apply_edge();
    WB_regwrite = 1'b0;
    #1;
    total++;
    if (rd1 !== 8'hEE) begin bad++; $display("FAIL mid_reset_after got=%h exp=ee", rd1); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      WB_regwrite = 1'($urandom_range(0, 1));
      WB_ImmLoad  = 1'($urandom_range(0, 1));
      WB_ALUres   = 8'($urandom);
      WB_ImmData  = 8'($urandom);
      WB_writereg = 3'($urandom);
      WB_instr    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      ID_readreg1 = 3'($urandom);
      ID_readreg2 = ($urandom_range(0, 2) == 0) ? WB_writereg : 3'($urandom);
      #1;
      total++;
      if (wdata !== exp_wdata() || rd1 !== exp_read(ID_readreg1) || rd2 !== exp_read(ID_readreg2)) begin
        bad++;
        $display("FAIL rand_read n=%0d got=%h/%h/%h exp=%h/%h/%h", n, wdata, rd1, rd2,
                 exp_wdata(), exp_read(ID_readreg1), exp_read(ID_readreg2));
      end
      apply_edge();
      total++;
      if (rcount !== 16'(m_cnt) || rcount_s !== 4'(m_cnt4) || lreg !== m_lreg || ldata !== m_ldata) begin
        bad++;
        $display("FAIL rand_state n=%0d got=%0d/%0d/%0d/%h exp=%0d/%0d/%0d/%h", n, rcount,
                 rcount_s, lreg, ldata, m_cnt, m_cnt4, m_lreg, m_ldata);
      end
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        model_clear();
        #1;
        total++;
        if (rd1 !== 8'h00 || rd2 !== 8'h00 || wdata !== exp_wdata()) begin
          bad++; $display("FAIL rand_reset n=%0d got=%h/%h/%h exp=00/00/%h", n, rd1, rd2, wdata, exp_wdata());
        end
        rst = 1'b1;
      end
    end
    WB_regwrite = 1'b0;
    WB_instr = 8'h00;
  endtask

  initial begin
    rst = 1'b0;
    WB_regwrite = 1'b0; WB_ImmLoad = 1'b0; WB_ALUres = 8'h00; WB_ImmData = 8'h00;
    WB_writereg = 3'd0; WB_instr = 8'h00; ID_readreg1 = 3'd0; ID_readreg2 = 3'd0;
    model_clear();
    #12;
    rst = 1'b1;
    #1;
    test_reset();
    test_commit_select();
    test_bypass();
    test_suppressed();
    test_retire();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
